clk_div_prog: RTL and testbench
===============================

// Module: clk_div_prog
// PURPOSE
//  Parametrised programmable integer clock divider; successor to the fixed 4-bit-ratio divider.
//  Sits in the clock block, generating UART TX/RX clocks from the reference clock.
//  Adds ratio width DIV_W, a registered rising-edge tick, boundary-only ratio updates and a ratio<2 bypass mode.
// PARAMETERS
//  DIV_W  8  width of division ratio and internal phase counter; legal divided ratios 2..2^DIV_W-1
// PORTS
//  i_ref_clk    in   1      reference clock; only clock in the block
//  i_rst        in   1      reset, synchronous, active-high
//  i_clk_en     in   1      divider enable
//  i_div_ratio  in   DIV_W  requested division ratio N
//  o_div_clk    out  1      divided clock, registered
//  o_div_tick   out  1      one-i_ref_clk pulse coinciding with each o_div_clk rise; every cycle in BYPASS
//  o_busy       out  1      high in HIGH or LOW state
// BEHAVIOUR
//  Reset: i_rst high at a posedge -> next cycle state=IDLE, counter=0, latched ratio=0,
//   o_div_clk=0, o_div_tick=0, o_busy=0. Applies mid-period, no completion.
//  Latched ratio R; high count H=R>>1, low count L=R-H (odd R: low phase one cycle longer). Period = R cycles.
//  States: IDLE, HIGH, LOW, BYPASS.
//   IDLE: en & N>=2 -> HIGH, latch R=N, counter=1, o_div_clk<=1, o_div_tick<=1.
//         en & N<2  -> BYPASS. !en -> stay IDLE.
//   HIGH: counter==H -> LOW, counter=1, o_div_clk<=0; else counter++.
//   LOW:  counter==L -> period boundary: en & N>=2 -> HIGH, latch new N, clk/tick as from IDLE;
//         en & N<2 -> BYPASS; else counter++.
//   BYPASS: o_div_clk=0, o_div_tick=1 every cycle; N>=2 -> HIGH as from IDLE.
//  o_div_tick is high for exactly one cycle per period, aligned with o_div_clk 0->1; 0 otherwise outside BYPASS.
//  Ratio changes mid-period are ignored until the period boundary; no runt or stretched phases.
//  i_clk_en low in any state -> next cycle IDLE, o_div_clk=0, tick=0, counter=0 (period abandoned).
//  First o_div_clk rise: 1 cycle after the en & N>=2 sample.
//  Counter is DIV_W bits; max L=2^(DIV_W-1) fits, so there is no wrap-around.
// CONFIGURATION
//  CLK_DIV_PROG_ALIGN_EN defined: adds port i_align (in, 1).
//   i_align high with en & N>=2 -> next cycle forced into HIGH, counter=1, N re-latched, clk=1, tick=1, from any state.
//   i_align has priority below i_rst and !i_clk_en.
//  Not defined: no i_align port; the phase is set only by enable/reset.
// STRUCTURE
//  Shared package clk_div_pkg: state encodings (IDLE=2'd0, HIGH=2'd1, LOW=2'd2, BYPASS=2'd3).
//  Single module; no sub-module is warranted (counter, latch and FSM are tightly coupled).
//  H/L derived combinationally from the latched R only, never from i_div_ratio.
// TESTING
//  N=4, en=1 -> o_div_clk 1,1,0,0 repeating; tick every 4th cycle on the rise.
//  N=5 -> high 2 cycles, low 3; N=255 (DIV_W=8) -> high 127, low 128, tick period 255.
//  N=4 -> 7 written mid-HIGH -> current period stays 2/2; next period is 3/4.
//  en dropped mid-LOW -> next cycle clk=0, busy=0; re-enable -> rise after 1 cycle.
//  N=1 or 0 with en -> clk=0, tick=1 every cycle; N=6 -> rises next cycle, then 3/3.
//  i_rst pulsed mid-HIGH with N=6 -> next cycle all outputs 0; release -> fresh period.

Source files
------------

// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared definitions for the programmable clock divider
//
// Purpose: state encoding and small helpers shared by clk_div_prog.
// Ports:   none (package).
package clk_div_pkg;

  // Divider FSM states; encodings are fixed so that they are stable across builds.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HIGH   = 2'd1,
    ST_LOW    = 2'd2,
    ST_BYPASS = 2'd3
  } div_state_t;

  // A divider is busy only while it is producing a real divided waveform.
  function automatic logic state_is_busy(input div_state_t st);
    return (st == ST_HIGH) || (st == ST_LOW);
  endfunction

endpackage

// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - parametrised programmable integer clock divider
//
// Purpose: divides i_ref_clk by a programmable integer ratio N (2..2^DIV_W-1).
//   The divided clock is high for R>>1 cycles and low for the remainder, so an
//   odd ratio gets the longer low phase. Ratio changes only take effect at a
//   period boundary. A ratio below 2 selects bypass: o_div_clk held low and
//   o_div_tick asserted every cycle.
// Configuration macro: CLK_DIV_PROG_ALIGN_EN adds input i_align, which restarts
//   the period (fresh HIGH phase, ratio re-latched) from any state.
// Ports:
//   i_ref_clk    in   1      reference clock (only clock in the block)
//   i_rst        in   1      synchronous active-high reset
//   i_clk_en     in   1      divider enable; low abandons the current period
//   i_div_ratio  in   DIV_W  requested division ratio N
//   i_align      in   1      phase realign request (CLK_DIV_PROG_ALIGN_EN only)
//   o_div_clk    out  1      registered divided clock
//   o_div_tick   out  1      one-cycle pulse on each o_div_clk rise; constant 1 in bypass
//   o_busy       out  1      high while in the HIGH or LOW phase
import clk_div_pkg::*;

module clk_div_prog #(
  parameter int DIV_W = 8
) (
  input  logic             i_ref_clk,
  input  logic             i_rst,
  input  logic             i_clk_en,
  input  logic [DIV_W-1:0] i_div_ratio,
`ifdef CLK_DIV_PROG_ALIGN_EN
  input  logic             i_align,
`endif
  output logic             o_div_clk,
  output logic             o_div_tick,
  output logic             o_busy
);

  localparam logic [DIV_W-1:0] CNT_ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0] RATIO_MIN = DIV_W'(2);

  div_state_t       state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] ratio_lat;

  // Phase lengths come from the latched ratio only, so a new request on
  // i_div_ratio can never shorten or stretch the period already running.
  logic [DIV_W-1:0] high_cnt;
  logic [DIV_W-1:0] low_cnt;
  logic             ratio_ok;
  logic             do_start;
  logic             do_bypass;

  assign high_cnt = ratio_lat >> 1;
  assign low_cnt  = ratio_lat - high_cnt;
  assign ratio_ok = (i_div_ratio >= RATIO_MIN);

  // Decide whether this cycle opens a fresh period or drops into bypass.
  // Only IDLE, BYPASS and the last LOW cycle are decision points.
  always_comb begin
    do_start  = 1'b0;
    do_bypass = 1'b0;
    case (state)
      ST_IDLE, ST_BYPASS: begin
        do_start  = ratio_ok;
        do_bypass = !ratio_ok;
      end
      ST_LOW: begin
        if (cnt == low_cnt) begin
          do_start  = ratio_ok;
          do_bypass = !ratio_ok;
        end
      end
      default: begin
        do_start  = 1'b0;
        do_bypass = 1'b0;
      end
    endcase
`ifdef CLK_DIV_PROG_ALIGN_EN
    // Realign overrides whatever phase we are in, but only towards a legal ratio.
    if (i_align && ratio_ok) begin
      do_start  = 1'b1;
      do_bypass = 1'b0;
    end
`endif
  end

  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      ratio_lat  <= '0;
      o_div_clk  <= 1'b0;
      o_div_tick <= 1'b0;
      o_busy     <= 1'b0;
    end else if (!i_clk_en) begin
      // Disable abandons the period; the latched ratio is kept but unused.
      state      <= ST_IDLE;
      cnt        <= '0;
      o_div_clk  <= 1'b0;
      o_div_tick <= 1'b0;
      o_busy     <= 1'b0;
    end else if (do_start) begin
      // First HIGH cycle is counted as 1, so the rise appears one cycle after the sample.
      state      <= ST_HIGH;
      cnt        <= CNT_ONE;
      ratio_lat  <= i_div_ratio;
      o_div_clk  <= 1'b1;
      o_div_tick <= 1'b1;
      o_busy     <= state_is_busy(ST_HIGH);
    end else if (do_bypass) begin
      state      <= ST_BYPASS;
      cnt        <= '0;
      o_div_clk  <= 1'b0;
      o_div_tick <= 1'b1;
      o_busy     <= state_is_busy(ST_BYPASS);
    end else begin
      o_div_tick <= 1'b0;
      case (state)
        ST_HIGH: begin
          if (cnt == high_cnt) begin
            state     <= ST_LOW;
            cnt       <= CNT_ONE;
            o_div_clk <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_LOW: begin
          // The boundary case (cnt == low_cnt) is always taken by do_start/do_bypass.
          cnt <= cnt + CNT_ONE;
        end
        default: begin
          // IDLE and BYPASS always resolve through do_start/do_bypass.
          state     <= ST_IDLE;
          cnt       <= '0;
          o_div_clk <= 1'b0;
          o_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - scoreboard testbench for clk_div_prog
//
// Purpose: drives directed ratio/enable/reset vectors, queues the expected
//   {o_div_clk, o_div_tick, o_busy} for every reference cycle, and a separate
//   monitor compares the DUT outputs on each falling edge.
// Ports: none (top-level testbench).
module tb_clk_div_prog;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] ratio;
  logic       align = 1'b0;
  logic       div_clk;
  logic       div_tick;
  logic       busy;

  typedef struct {
    logic [2:0] val;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  clk_div_prog #(.DIV_W(8)) dut (
    .i_ref_clk  (clk),
    .i_rst      (rst),
    .i_clk_en   (en),
    .i_div_ratio(ratio),
`ifdef CLK_DIV_PROG_ALIGN_EN
    .i_align    (align),
`endif
    .o_div_clk  (div_clk),
    .o_div_tick (div_tick),
    .o_busy     (busy)
  );

  // Monitor: one expectation per reference cycle, checked away from the rising edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if ({div_clk, div_tick, busy} !== e.val) begin
        errors++;
        $display("FAIL %s @%0t: got clk/tick/busy=%b required %b",
                 e.nm, $time, {div_clk, div_tick, busy}, e.val);
      end
    end
  end

  // Apply one cycle of inputs and queue the outputs expected after that edge.
  task automatic cyc(input logic r, input logic e, input logic [7:0] n,
                     input logic [2:0] exp_val, input string nm);
    exp_t x;
    rst   = r;
    en    = e;
    ratio = n;
    x.val = exp_val;
    x.nm  = nm;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // Steady divided output for ratio r starting at a period boundary:
  // high for floor(r/2) cycles, tick on the first cycle only.
  task automatic periods(input logic [7:0] n, input int r, input int ncyc, input string nm);
    for (int k = 0; k < ncyc; k++) begin
      int kk;
      kk = k % r;
      cyc(1'b0, 1'b1, n, {(kk < r / 2), (kk == 0), 1'b1}, nm);
    end
  endtask

  initial begin
    // Reset and disabled idle
    cyc(1'b1, 1'b0, 8'd0, 3'b000, "reset0");
    cyc(1'b1, 1'b1, 8'd4, 3'b000, "reset1");
    cyc(1'b0, 1'b0, 8'd4, 3'b000, "idle_disabled");

    // N=4: 1,1,0,0; then N=5: 2 high / 3 low
    periods(8'd4, 4, 12, "n4");
    periods(8'd5, 5, 10, "n5");

    // N=4 -> 7 mid-HIGH: this period stays 2/2, the next is 3/4
    cyc(1'b0, 1'b1, 8'd4, 3'b111, "chg_k0");
    cyc(1'b0, 1'b1, 8'd7, 3'b101, "chg_k1");
    cyc(1'b0, 1'b1, 8'd7, 3'b001, "chg_k2");
    cyc(1'b0, 1'b1, 8'd7, 3'b001, "chg_k3");
    periods(8'd7, 7, 7, "n7");

    // Enable dropped mid-LOW, then re-enabled with N=6
    periods(8'd7, 7, 5, "n7_pre_off");
    cyc(1'b0, 1'b0, 8'd7, 3'b000, "en_off0");
    cyc(1'b0, 1'b0, 8'd7, 3'b000, "en_off1");
    periods(8'd6, 6, 12, "reenable_n6");

    // Bypass with N=1 and N=0, then leave with N=6
    cyc(1'b0, 1'b1, 8'd1, 3'b010, "bypass_n1_0");
    cyc(1'b0, 1'b1, 8'd1, 3'b010, "bypass_n1_1");
    cyc(1'b0, 1'b1, 8'd1, 3'b010, "bypass_n1_2");
    cyc(1'b0, 1'b1, 8'd0, 3'b010, "bypass_n0_0");
    cyc(1'b0, 1'b1, 8'd0, 3'b010, "bypass_n0_1");
    periods(8'd6, 6, 6, "bypass_exit_n6");

    // Smallest ratios
    periods(8'd2, 2, 4, "n2");
    periods(8'd3, 3, 6, "n3");

    // Reset mid-HIGH with N=6, then a fresh period
    cyc(1'b0, 1'b1, 8'd6, 3'b111, "pre_rst_k0");
    cyc(1'b0, 1'b1, 8'd6, 3'b101, "pre_rst_k1");
    cyc(1'b1, 1'b1, 8'd6, 3'b000, "rst_mid_high");
    periods(8'd6, 6, 6, "post_rst_n6");

    // Largest ratio: 127 high, 128 low, then the next rise
    periods(8'd255, 255, 256, "n255");
    cyc(1'b0, 1'b0, 8'd0, 3'b000, "final_off");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
